tagged_mem_responder: RTL

Memory-side responder for the tagged processor-to-memory bus driven by `cache_controller`: accepts one LOAD or STORE per cycle and returns a nonzero transaction tag in the same cycle. It services loads from an internal 64-bit-word store after a fixed latency, echoing the tag alongside the data. It is synthesizable and drop-in on the memory side of the controller, so cache and controller benches have a deterministic, parameterizable backing store.

---
 rtl/tagged_mem_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/tagged_mem_responder.sv
// Memory-side responder for the tagged processor-to-memory bus.
// It accepts one LOAD or STORE per cycle and returns each load's data after a fixed latency, echoing the load's tag.
module tagged_mem_responder #(
    parameter int XLEN            = 32,
    parameter int MEM_DEPTH       = 256,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [3:0]       MAX_OUT_C = 4'(MAX_OUTSTANDING);
    localparam logic [3:0]       CNT_INIT  = 4'(LATENCY - 1);

    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    // Tag 0 means "not accepted", so the sequence wraps from 15 back to 1.
    function automatic logic [3:0] tag_inc(input logic [3:0] t);
        return (t == 4'd15) ? 4'd1 : t + 4'd1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    logic [63:0]      storage [MEM_DEPTH];
    logic [3:0]       q_tag   [MAX_OUTSTANDING];
    logic [63:0]      q_data  [MAX_OUTSTANDING];
    logic [3:0]       q_cnt   [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [3:0]       count;
    logic [3:0]       next_tag;
    logic [3:0]       ret_tag_p1;
    logic [63:0]      ret_data_p1;

    logic [IDX_W-1:0] idx;
    logic             fifo_full;
    logic             accept_load;
    logic             accept_store;
    logic             pop;
    logic             unused_addr_bits;

    assign idx              = proc2mem_addr[IDX_W+2:3];
    assign unused_addr_bits = ^{proc2mem_addr[2:0], proc2mem_addr[XLEN-1:IDX_W+3]};

    // Fullness is judged on the occupancy at the start of the cycle, so a same-cycle pop does not make room.
    assign fifo_full    = (count == MAX_OUT_C);
    assign accept_load  = !reset && (proc2mem_command == CMD_LOAD) && !fifo_full;
    assign accept_store = !reset && (proc2mem_command == CMD_STORE);
    assign mem2proc_response = (accept_load || accept_store) ? next_tag : 4'd0;

    // Pop the head when its countdown reaches zero this cycle, so data is valid LATENCY cycles after acceptance.
    assign pop = (count != 4'd0) && (sat_dec(q_cnt[rd_ptr]) == 4'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            next_tag    <= 4'd1;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= 4'd0;
            ret_tag_p1  <= 4'd0;
            ret_data_p1 <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) storage[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) q_cnt[i] <= sat_dec(q_cnt[i]);

            if (accept_store) storage[idx] <= proc2mem_data;

            if (accept_load) begin
                q_tag[wr_ptr]  <= next_tag;
                q_data[wr_ptr] <= storage[idx];
                q_cnt[wr_ptr]  <= CNT_INIT;
                wr_ptr         <= ptr_inc(wr_ptr);
            end

            if (pop) rd_ptr <= ptr_inc(rd_ptr);

            count <= count + 4'(accept_load) - 4'(pop);

            if (accept_load || accept_store) next_tag <= tag_inc(next_tag);

            // Return stage: one-cycle registered tag/data, zero when nothing returns.
            ret_tag_p1  <= pop ? q_tag[rd_ptr]  : 4'd0;
            ret_data_p1 <= pop ? q_data[rd_ptr] : 64'd0;
        end
    end

    assign mem2proc_tag  = ret_tag_p1;
    assign mem2proc_data = ret_data_p1;

endmodule
